// File: rtl/vsm_pkg.sv
// Shared definitions for the phase sequencer.
//   state_e      : top-level sequencer state (IDLE / RUN)
//   ENC_ONEHOT   : phase register holds a one-hot code, one bit per phase
//   ENC_BINARY   : phase register holds the binary phase index
//   idx_width()  : width of a phase index, never less than one bit
package vsm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int ENC_ONEHOT = 0;
  localparam int ENC_BINARY = 1;

  function automatic int idx_width(input int num_phases);
    return (num_phases > 1) ? $clog2(num_phases) : 1;
  endfunction

endpackage

// File: rtl/vsm_phase_decode.sv
// Decodes the phase register into one-hot strobes and a binary index and
// checks that the register holds a legal code.
// Ports:
//   run         in  sequencer is in RUN (code is only meaningful then)
//   code        in  phase register, one-hot or binary depending on ENCODING
//   phase       out one-hot phase strobes, all zero when idle or corrupt
//   phase_index out binary phase index, zero when idle or corrupt
//   legal       out code is valid for the current state
module vsm_phase_decode
  import vsm_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int ENCODING   = ENC_ONEHOT,
  localparam int IDX_W     = idx_width(NUM_PHASES),
  localparam int SREG_W    = (ENCODING == ENC_ONEHOT) ? NUM_PHASES : IDX_W
) (
  input  logic                  run,
  input  logic [SREG_W-1:0]     code,
  output logic [NUM_PHASES-1:0] phase,
  output logic [IDX_W-1:0]      phase_index,
  output logic                  legal
);

  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_PHASES - 1);

  if (ENCODING == ENC_ONEHOT) begin : g_onehot
    always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // that no path through the block leaves it unassigned (which would
      // infer a latch).
      phase       = '0;
      phase_index = '0;
      legal       = !run || ($countones(code) == 1);
      if (run && legal) begin
        phase = code;
        for (int i = 0; i < NUM_PHASES; i++) begin
          if (code[i]) phase_index = IDX_W'(i);
        end
      end
    end
  end else begin : g_binary
    always_comb begin
      phase       = '0;
      phase_index = '0;
      legal       = !run || (code <= LAST_MAX);
      if (run && legal) begin
        phase       = NUM_PHASES'(1) << code;
        phase_index = code;
      end
    end
  end

endmodule

// File: rtl/vsm_phase_sequencer.sv
// Instruction-phase sequencer: walks phases 0..Last_Phase once per
// instruction cycle while Run is high, with stall (Hold), abort and
// corrupt-state recovery.
// Ports:
//   Phase_Count  in  clock
//   Clear        in  synchronous active-high reset
//   Run          in  start / continue instruction cycles
//   Hold         in  freeze the current phase
//   Abort        in  drop the current cycle, return to idle
//   Last_Phase   in  final phase index of the next cycle (clamped)
//   Phase        out one-hot phase strobes (zero when idle)
//   Phase_Index  out binary index of the active phase (zero when idle)
//   Busy         out sequencer is in RUN
//   Cycle_Done   out final phase of a cycle that completes on this edge
//   Cycle_Count  out completed cycles, wraps
//   Err_Illegal  out one-cycle pulse after a corrupt phase register is seen
module vsm_phase_sequencer
  import vsm_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int ENCODING   = ENC_ONEHOT,
  parameter int CNT_W      = 8,
  localparam int IDX_W     = idx_width(NUM_PHASES)
) (
  input  logic                  Phase_Count,
  input  logic                  Clear,
  input  logic                  Run,
  input  logic                  Hold,
  input  logic                  Abort,
  input  logic [IDX_W-1:0]      Last_Phase,
  output logic [NUM_PHASES-1:0] Phase,
  output logic [IDX_W-1:0]      Phase_Index,
  output logic                  Busy,
  output logic                  Cycle_Done,
  output logic [CNT_W-1:0]      Cycle_Count,
  output logic                  Err_Illegal
);

  localparam int SREG_W = (ENCODING == ENC_ONEHOT) ? NUM_PHASES : IDX_W;
  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_PHASES - 1);

  state_e             state_q, state_d;
  logic [SREG_W-1:0]  sreg_q, sreg_d;
  logic [IDX_W-1:0]   last_q, last_d, last_in;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q;
  logic               legal, at_last, start;

  vsm_phase_decode #(
    .NUM_PHASES (NUM_PHASES),
    .ENCODING   (ENCODING)
  ) u_decode (
    .run         (state_q == ST_RUN),
    .code        (sreg_q),
    .phase       (Phase),
    .phase_index (idx),
    .legal       (legal)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx;
    last_d     = last_q;
    cnt_d      = cnt_q;
    start      = 1'b0;
    Cycle_Done = 1'b0;
    last_in    = (Last_Phase > LAST_MAX) ? LAST_MAX : Last_Phase;
    at_last    = (state_q == ST_RUN) && legal && (idx == last_q);

    // Corrupt register recovery outranks everything except Clear; Clear is
    // applied in the register process so it overrides all of this.
    if ((state_q == ST_RUN) && !legal) begin
      state_d = ST_IDLE;
    end else if (Abort) begin
      state_d = ST_IDLE;
    end else if (!Hold) begin
      if (state_q == ST_IDLE) begin
        start = Run;
      end else if (at_last) begin
        cnt_d      = cnt_q + CNT_W'(1);
        Cycle_Done = !Clear;
        if (Run) start = 1'b1;
        else     state_d = ST_IDLE;
      end else begin
        idx_d = idx + IDX_W'(1);
      end
    end

    // Last_Phase is sampled only on edges that enter phase 0.
    if (start) begin
      state_d = ST_RUN;
      idx_d   = '0;
      last_d  = last_in;
    end

    if (state_d == ST_IDLE)            sreg_d = '0;
    else if (ENCODING == ENC_ONEHOT)   sreg_d = SREG_W'(1) << idx_d;
    else                               sreg_d = SREG_W'(idx_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge Phase_Count) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      last_q  <= LAST_MAX;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= (state_q == ST_RUN) && !legal;
    end
  end

  assign Phase_Index = idx;
  assign Busy        = (state_q == ST_RUN);
  assign Cycle_Count = cnt_q;
  assign Err_Illegal = err_q;

endmodule

// File: tb/tb_vsm_phase_sequencer.sv
// Self-checking bench: one-hot and binary variants driven in lock-step,
// both compared against a behavioural model through an expectation queue.
module tb_vsm_phase_sequencer;
  import vsm_pkg::*;

  localparam int N  = 5;
  localparam int IW = 3;
  localparam int CW = 8;

  logic          clk   = 1'b0;
  logic          clear = 1'b1;
  logic          run   = 1'b0;
  logic          hold  = 1'b0;
  logic          abort = 1'b0;
  logic [IW-1:0] lp    = '0;

  logic [N-1:0]  phase0, phase1;
  logic [IW-1:0] idx0, idx1;
  logic          busy0, busy1, done0, done1, err0, err1;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  vsm_phase_sequencer #(.NUM_PHASES(N), .ENCODING(ENC_ONEHOT), .CNT_W(CW)) dut0 (
    .Phase_Count(clk), .Clear(clear), .Run(run), .Hold(hold), .Abort(abort),
    .Last_Phase(lp), .Phase(phase0), .Phase_Index(idx0), .Busy(busy0),
    .Cycle_Done(done0), .Cycle_Count(cnt0), .Err_Illegal(err0));

  vsm_phase_sequencer #(.NUM_PHASES(N), .ENCODING(ENC_BINARY), .CNT_W(CW)) dut1 (
    .Phase_Count(clk), .Clear(clear), .Run(run), .Hold(hold), .Abort(abort),
    .Last_Phase(lp), .Phase(phase1), .Phase_Index(idx1), .Busy(busy1),
    .Cycle_Done(done1), .Cycle_Count(cnt1), .Err_Illegal(err1));

  typedef struct packed {
    logic [N-1:0]  phase;
    logic [IW-1:0] idx;
    logic          busy;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Behavioural model state
  bit m_run     = 1'b0;
  int m_idx     = 0;
  int m_last    = N - 1;
  int m_cnt     = 0;
  bit m_err     = 1'b0;
  bit m_illegal = 1'b0;

  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function int clampi(input int v);
    return (v > N - 1) ? N - 1 : v;
  endfunction

  task model_step(input bit c, input bit r, input bit h, input bit a, input int l);
    exp_t e;
    if (c) begin
      m_run = 0; m_idx = 0; m_last = N - 1; m_cnt = 0; m_err = 0;
    end else begin
      m_err = m_illegal;
      if (m_run && m_illegal) begin
        m_run = 0; m_idx = 0;
      end else if (a) begin
        m_run = 0; m_idx = 0;
      end else if (!h) begin
        if (!m_run) begin
          if (r) begin m_run = 1; m_idx = 0; m_last = clampi(l); end
        end else if (m_idx == m_last) begin
          m_cnt = (m_cnt + 1) % 256;
          if (r) begin m_idx = 0; m_last = clampi(l); end
          else   begin m_run = 0; m_idx = 0; end
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end
    m_illegal = 0;
    e.phase = m_run ? (N'(1) << m_idx) : '0;
    e.idx   = m_run ? IW'(m_idx) : '0;
    e.busy  = m_run;
    e.cnt   = CW'(m_cnt);
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  // Runs n clock cycles with fixed inputs; inj corrupts both phase registers
  // during the first of those cycles.
  task cyc(input bit c, input bit r, input bit h, input bit a, input int l,
           input int n, input bit inj = 1'b0);
    exp_t e;
    bit   exp_done;
    for (int k = 0; k < n; k++) begin
      clear = c; run = r; hold = h; abort = a; lp = IW'(l);
      if (inj && k == 0) begin
        force dut0.sreg_q = 5'b00110;
        force dut1.sreg_q = 3'd6;
        m_illegal = 1'b1;
      end
      #1;
      exp_done = m_run && !m_illegal && (m_idx == m_last) && !h && !a && !c;
      check("cycle_done_onehot", done0, exp_done);
      check("cycle_done_binary", done1, exp_done);
      if (m_illegal) begin
        check("detect_phase_onehot", phase0, 0);
        check("detect_phase_binary", phase1, 0);
        check("detect_index_binary", idx1, 0);
      end
      model_step(c, r, h, a, l);
      @(posedge clk);
      #1;
      if (inj && k == 0) begin
        release dut0.sreg_q;
        release dut1.sreg_q;
      end
      e = exp_q.pop_front();
      check("phase_onehot", phase0, e.phase);
      check("phase_binary", phase1, e.phase);
      check("index_onehot", idx0, e.idx);
      check("index_binary", idx1, e.idx);
      check("busy_onehot", busy0, e.busy);
      check("busy_binary", busy1, e.busy);
      check("count_onehot", cnt0, e.cnt);
      check("count_binary", cnt1, e.cnt);
      check("err_onehot", err0, e.err);
      check("err_binary", err1, e.err);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    cyc(1, 0, 0, 0, 0, 2);
    // Continuous run, 5-phase cycles: three completions after 15 RUN cycles
    cyc(0, 1, 0, 0, 4, 16);
    check("walk_count", cnt0, 3);
    check("walk_phase", phase0, 5'b00001);
    // Last_Phase=2 latched at the wrap, then changed to 4 mid-cycle
    cyc(0, 1, 0, 0, 2, 5);
    cyc(0, 1, 0, 0, 2, 1);
    cyc(0, 1, 0, 0, 4, 1);
    check("short_cycle_end", phase0, 5'b00100);
    cyc(0, 1, 0, 0, 4, 6);
    // Hold for three edges in phase 3, then resume to phase 4
    cyc(0, 1, 0, 0, 4, 3);
    cyc(0, 1, 1, 0, 4, 3);
    check("hold_phase", phase0, 5'b01000);
    cyc(0, 1, 0, 0, 4, 1);
    // Abort with Hold in phase 2
    cyc(0, 1, 0, 0, 4, 3);
    cyc(0, 1, 1, 1, 4, 1);
    check("abort_count", cnt0, 7);
    // Hold and Abort in idle block the start
    cyc(0, 1, 1, 0, 4, 2);
    cyc(0, 1, 0, 1, 4, 1);
    // Corrupt phase register in phase 2
    cyc(0, 1, 0, 0, 4, 3);
    cyc(0, 1, 0, 0, 4, 1, 1'b1);
    cyc(0, 0, 0, 0, 4, 2);
    // Run dropped at the last phase ends in idle
    cyc(0, 1, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 1, 2);
    // One-phase cycles
    cyc(0, 1, 0, 0, 0, 4);
    // Clear during phase 3 with Cycle_Count=7
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 7);
    cyc(0, 1, 0, 0, 4, 4);
    check("pre_clear_count", cnt0, 7);
    cyc(1, 1, 0, 0, 4, 1);
    // Last_Phase=7 clamps to a 5-phase cycle
    cyc(0, 1, 0, 0, 7, 11);
    check("clamp_count", cnt0, 2);
    // Counter wrap
    cyc(0, 1, 0, 0, 0, 260);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
